// File: rtl/clkdiv_pkg.sv
// Shared types, reset defaults and configuration legality check for the
// clock-enable divider controller.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_e;

  localparam int unsigned CLKDIV_DEF_DIV  = 50;
  localparam int unsigned CLKDIV_DEF_HIGH = 25;

  // A period needs at least one high and one low cycle.
  function automatic logic cfg_legal(input int unsigned div, input int unsigned high);
    return (div >= 2) && (high >= 1) && (high < div);
  endfunction

endpackage

// File: rtl/clkdiv_core.sv
// Period counter with high-time compare; all waveform outputs are registered
// from the next count value so they line up with count.
module clkdiv_core #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             run_i,
  input  logic             halt_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] high_i,
  output logic             wrap_o,
  output logic [CNT_W-1:0] count_o,
  output logic             tick_o,
  output logic             div_out_o
);

  logic [CNT_W-1:0] count_q, count_d, cnt_nx;
  logic             tick_q, tick_d;
  logic             div_out_q, div_out_d;
  logic             active;

  assign wrap_o = run_i && (count_q == div_i - CNT_W'(1));

  always_comb begin
    active    = start_i || (run_i && !halt_i);
    cnt_nx    = (start_i || wrap_o) ? '0 : count_q + CNT_W'(1);
    count_d   = active ? cnt_nx : '0;
    tick_d    = active && (cnt_nx == '0);
    div_out_d = active && (cnt_nx < high_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      tick_q    <= 1'b0;
      div_out_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tick_q    <= tick_d;
      div_out_q <= div_out_d;
    end
  end

  assign count_o   = count_q;
  assign tick_o    = tick_q;
  assign div_out_o = div_out_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run-time controller for the programmable clock-enable divider: config
// handshake with period-boundary shadow update, start/stop and bursts.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned DEF_DIV  = CLKDIV_DEF_DIV,
  parameter int unsigned DEF_HIGH = CLKDIV_DEF_HIGH,
  parameter int unsigned BURST_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               div_out,
  output logic               tick,
  output logic [CNT_W-1:0]   count,
  output logic               done
);

  state_e             state_q;
  logic [CNT_W-1:0]   div_q, high_q, sh_div_q, sh_high_q;
  logic [BURST_W-1:0] burst_q, sh_burst_q, bcnt_q;
  logic               sh_valid_q, cfg_ready_q, cfg_err_q, done_q, busy_q;
  logic               accept, legal, run, start_run, wrap, burst_end, ending;

  assign accept    = cfg_valid && cfg_ready_q;
  assign legal     = cfg_legal(32'(cfg_div), 32'(cfg_high));
  assign run       = (state_q != IDLE);
  assign start_run = (state_q == IDLE) && start;
  assign burst_end = (burst_q != '0) && (bcnt_q == burst_q - BURST_W'(1));
  assign ending    = wrap && ((state_q == STOPPING) || burst_end);

  clkdiv_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_run),
    .run_i    (run),
    .halt_i   (ending),
    .div_i    (div_q),
    .high_i   (high_q),
    .wrap_o   (wrap),
    .count_o  (count),
    .tick_o   (tick),
    .div_out_o(div_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      div_q       <= CNT_W'(DEF_DIV);
      high_q      <= CNT_W'(DEF_HIGH);
      burst_q     <= '0;
      sh_div_q    <= '0;
      sh_high_q   <= '0;
      sh_burst_q  <= '0;
      sh_valid_q  <= 1'b0;
      bcnt_q      <= '0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cfg_err_q <= accept && !legal;
      done_q    <= ending;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            bcnt_q  <= '0;
          end
        end
        RUN: begin
          if (ending) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (stop) begin
            state_q <= STOPPING;
          end
        end
        STOPPING: begin
          if (ending) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (wrap) bcnt_q <= bcnt_q + BURST_W'(1);

      if (wrap && sh_valid_q) begin
        div_q       <= sh_div_q;
        high_q      <= sh_high_q;
        burst_q     <= sh_burst_q;
        sh_valid_q  <= 1'b0;
        cfg_ready_q <= 1'b1;
      end

      // cfg_ready is low whenever the shadow is full, so this never collides
      // with the shadow apply above; a transfer on the run's final wrap goes
      // straight to the active registers since the next period starts idle.
      if (accept && legal) begin
        if (!run || ending) begin
          div_q   <= cfg_div;
          high_q  <= cfg_high;
          burst_q <= cfg_burst;
        end else begin
          sh_div_q    <= cfg_div;
          sh_high_q   <= cfg_high;
          sh_burst_q  <= cfg_burst;
          sh_valid_q  <= 1'b1;
          cfg_ready_q <= 1'b0;
        end
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Scoreboard bench for clkdiv_ctrl: stimulus queues hand-computed output
// change events, a monitor pops and compares on every change of the outputs.
module tb_clkdiv_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready, cfg_err;
  logic [5:0] cfg_div, cfg_high, count;
  logic [7:0] cfg_burst;
  logic       start, stop, busy, div_out, tick, done;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned tag = 0;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  vec;
    logic [5:0]  cnt;
    int unsigned tag;
  } exp_t;

  exp_t exp_q[$];

  // vec = {busy, div_out, tick, done, cfg_err, cfg_ready}
  localparam logic [5:0] V_RST  = 6'b000001;
  localparam logic [5:0] V_T0   = 6'b111001;
  localparam logic [5:0] V_HI   = 6'b110001;
  localparam logic [5:0] V_LO   = 6'b100001;
  localparam logic [5:0] V_DN   = 6'b000101;
  localparam logic [5:0] V_ERRI = 6'b000011;

  clkdiv_ctrl #(
    .CNT_W   (6),
    .DEF_DIV (50),
    .DEF_HIGH(25),
    .BURST_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_burst(cfg_burst),
    .cfg_err  (cfg_err),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .div_out  (div_out),
    .tick     (tick),
    .count    (count),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] prev_vec = 6'bxxxxxx;

  always @(negedge clk) begin
    logic [5:0] vec;
    exp_t       e;
    vec = {busy, div_out, tick, done, cfg_err, cfg_ready};
    if (vec !== prev_vec) begin
      prev_vec = vec;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cyc=%0d vec=%b count=%0d, required no change", cyc, vec, count);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.vec !== vec || e.cnt !== count) begin
          errors++;
          $display("FAIL ev%0d: got cyc=%0d vec=%b count=%0d, required cyc=%0d vec=%b count=%0d",
                   e.tag, cyc, vec, count, e.cyc, e.vec, e.cnt);
        end
      end
    end
  end

  task automatic push(input int unsigned t, input logic [5:0] v, input int unsigned c);
    exp_t e;
    e.cyc = t;
    e.vec = v;
    e.cnt = 6'(c);
    e.tag = tag;
    tag++;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic offer(input int unsigned d, input int unsigned h, input int unsigned b);
    cfg_valid = 1'b1;
    cfg_div   = 6'(d);
    cfg_high  = 6'(h);
    cfg_burst = 8'(b);
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d events pending, required 0 (next expected cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d events pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k, s;
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_high  = '0;
    cfg_burst = '0;
    start     = 1'b0;
    stop      = 1'b0;
    push(1, V_RST, 0);
    wait_cyc(2);
    rst = 1'b1;

    // defaults 50/25, two periods, then graceful stop
    k = cyc + 1; s = k + 1;
    for (int unsigned p = 0; p < 2; p++) begin
      push(s + 50*p, V_T0, 0);
      push(s + 50*p + 1, V_HI, 1);
      push(s + 50*p + 25, V_LO, 25);
    end
    push(s + 100, V_DN, 0);
    push(s + 101, V_RST, 0);
    wait_cyc(k); start = 1'b1;
    wait_cyc(k + 1); start = 1'b0;
    wait_cyc(s + 59); stop = 1'b1;
    wait_cyc(s + 60); stop = 1'b0;
    drain(100);

    // stop while idle has no visible effect
    k = cyc + 1;
    wait_cyc(k); stop = 1'b1;
    wait_cyc(k + 1); stop = 1'b0;
    wait_cyc(k + 6);

    // idle config 4/1 burst 3
    k = cyc + 1; s = k + 2;
    for (int unsigned p = 0; p < 3; p++) begin
      push(s + 4*p, V_T0, 0);
      push(s + 4*p + 1, V_LO, 1);
    end
    push(s + 12, V_DN, 0);
    push(s + 13, V_RST, 0);
    wait_cyc(k); offer(4, 1, 3);
    wait_cyc(k + 1); cfg_valid = 1'b0; start = 1'b1;
    wait_cyc(k + 2); start = 1'b0;
    drain(40);

    // 4/2 running, 6/3 offered at count 1; start+stop together in idle
    k = cyc + 1; s = k + 2;
    push(s, V_T0, 0);
    push(s + 1, V_HI, 1);
    push(s + 2, 6'b100000, 2);
    push(s + 4, V_T0, 0);
    push(s + 5, V_HI, 1);
    push(s + 7, V_LO, 3);
    push(s + 10, V_T0, 0);
    push(s + 11, V_HI, 1);
    push(s + 13, V_LO, 3);
    push(s + 16, V_DN, 0);
    push(s + 17, V_RST, 0);
    wait_cyc(k); offer(4, 2, 0);
    wait_cyc(k + 1); cfg_valid = 1'b0; start = 1'b1; stop = 1'b1;
    wait_cyc(k + 2); start = 1'b0; stop = 1'b0;
    wait_cyc(s + 1); offer(6, 3, 0);
    wait_cyc(s + 2); cfg_valid = 1'b0;
    wait_cyc(s + 12); stop = 1'b1;
    wait_cyc(s + 13); stop = 1'b0;
    drain(40);

    // illegal offers in idle and while running; 6/3 stays active
    k = cyc + 1; s = k + 10;
    for (int unsigned i = 0; i < 3; i++) begin
      push(k + 3*i + 1, V_ERRI, 0);
      push(k + 3*i + 2, V_RST, 0);
    end
    push(s, V_T0, 0);
    push(s + 1, V_HI, 1);
    push(s + 2, 6'b110011, 2);
    push(s + 3, V_LO, 3);
    push(s + 6, V_T0, 0);
    push(s + 7, V_HI, 1);
    push(s + 9, V_LO, 3);
    push(s + 12, V_DN, 0);
    push(s + 13, V_RST, 0);
    wait_cyc(k);     offer(1, 1, 0);
    wait_cyc(k + 1); cfg_valid = 1'b0;
    wait_cyc(k + 3); offer(6, 0, 0);
    wait_cyc(k + 4); cfg_valid = 1'b0;
    wait_cyc(k + 6); offer(5, 5, 0);
    wait_cyc(k + 7); cfg_valid = 1'b0;
    wait_cyc(k + 9); start = 1'b1;
    wait_cyc(k + 10); start = 1'b0;
    wait_cyc(s + 1); offer(3, 3, 0);
    wait_cyc(s + 2); cfg_valid = 1'b0;
    wait_cyc(s + 7); stop = 1'b1;
    wait_cyc(s + 8); stop = 1'b0;
    drain(40);

    // div 8 high 4, stop at count 2
    k = cyc + 1; s = k + 2;
    push(s, V_T0, 0);
    push(s + 1, V_HI, 1);
    push(s + 4, V_LO, 4);
    push(s + 8, V_DN, 0);
    push(s + 9, V_RST, 0);
    wait_cyc(k); offer(8, 4, 0);
    wait_cyc(k + 1); cfg_valid = 1'b0; start = 1'b1;
    wait_cyc(k + 2); start = 1'b0;
    wait_cyc(s + 2); stop = 1'b1;
    wait_cyc(s + 3); stop = 1'b0;
    drain(40);

    // 3/2 burst 1 with start held across the done edge
    k = cyc + 1; s = k + 2;
    for (int unsigned r = 0; r < 2; r++) begin
      push(s + 4*r, V_T0, 0);
      push(s + 4*r + 1, V_HI, 1);
      push(s + 4*r + 2, V_LO, 2);
      push(s + 4*r + 3, V_DN, 0);
    end
    push(s + 8, V_RST, 0);
    wait_cyc(k); offer(3, 2, 1);
    wait_cyc(k + 1); cfg_valid = 1'b0; start = 1'b1;
    wait_cyc(s + 7); start = 1'b0;
    drain(40);

    // reset pulse mid-burst with a pending shadow, then defaults again
    k = cyc + 1; s = k + 2;
    push(s, V_T0, 0);
    push(s + 1, V_HI, 1);
    push(s + 2, 6'b110000, 2);
    push(s + 3, 6'b100000, 3);
    push(s + 4, V_RST, 0);
    wait_cyc(k); offer(7, 3, 4);
    wait_cyc(k + 1); cfg_valid = 1'b0; start = 1'b1;
    wait_cyc(k + 2); start = 1'b0;
    wait_cyc(s + 1); offer(4, 2, 0);
    wait_cyc(s + 2); cfg_valid = 1'b0;
    wait_cyc(s + 3);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    drain(20);

    k = cyc + 1; s = k + 1;
    push(s, V_T0, 0);
    push(s + 1, V_HI, 1);
    push(s + 25, V_LO, 25);
    push(s + 50, V_DN, 0);
    push(s + 51, V_RST, 0);
    wait_cyc(k); start = 1'b1;
    wait_cyc(k + 1); start = 1'b0;
    wait_cyc(s + 30); stop = 1'b1;
    wait_cyc(s + 31); stop = 1'b0;
    drain(60);

    wait_cyc(cyc + 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
